// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Brief   : Boot-time loader; packs a length-prefixed byte stream big-endian
//           into 32-bit words and writes them to instruction memory from 0.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [16:0] c_cap = 17'(2 ** ADDR_W);

  state_t          r_state;
  logic [1:0]      r_byte_cnt;
  logic [7:0]      r_hdr_hi;
  logic [23:0]     r_word;
  logic [ADDR_W:0] r_count;

  logic            w_xfer;
  logic [15:0]     w_hdr;
  logic [ADDR_W:0] w_next_words;

  assign w_xfer       = in_valid && in_ready;
  assign w_hdr        = {r_hdr_hi, in_data};
  assign w_next_words = words_loaded + (ADDR_W+1)'(1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= 2'd0;
      r_hdr_hi     <= 8'd0;
      r_word       <= 24'd0;
      r_count      <= '0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          // Hold drops one edge after DONE entry, after the final write strobe.
          if (r_state == S_DONE) cpu_hold <= 1'b0;
          if (start) begin
            r_state      <= S_HDR;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            r_byte_cnt   <= 2'd0;
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            if (r_byte_cnt == 2'd0) begin
              r_hdr_hi   <= in_data;
              r_byte_cnt <= 2'd1;
            end else begin
              r_byte_cnt <= 2'd0;
              if (w_hdr == 16'd0) begin
                r_state  <= S_DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
              end else if ({1'b0, w_hdr} > c_cap) begin
                r_state  <= S_ERR;
                in_ready <= 1'b0;
                error    <= 1'b1;
              end else begin
                r_state <= S_DATA;
                r_count <= (ADDR_W+1)'(w_hdr);
              end
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              imem_wdata   <= {r_word, in_data};
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_we      <= 1'b1;
              words_loaded <= w_next_words;
              if (w_next_words == r_count) begin
                r_state  <= S_DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              r_word <= {r_word[15:0], in_data};
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_loader
// Brief   : Randomized scoreboard bench for imem_loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;
  int we_count = 0;
  logic prev_we = 1'b0;
  logic [AW+31:0] exp_q[$];
  logic [31:0] img[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge Clk) begin
    if (Reset) begin
      if (imem_we) begin
        we_count++;
        if (exp_q.size() == 0) chk("unexpected_write", {imem_addr, imem_wdata}, 0);
        else chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
        chk("hold_during_we", cpu_hold, 1);
        if (prev_we) chk("we_width", 2, 1);
      end
      prev_we = imem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int t;
    if (thr) while ($urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      @(negedge Clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge Clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Reference: header N, then img[0..N-1] written to addresses 0..N-1.
  task automatic run_load(input int n, input bit thr);
    int we0;
    logic [31:0] w;
    bit over;
    over = (n > (1 << AW));
    if (!over) for (int i = 0; i < n; i++) exp_q.push_back({i[AW-1:0], img[i]});
    we0 = we_count;
    pulse_start();
    chk("hold_after_start", cpu_hold, 1);
    chk("done_cleared", done, 0);
    w = n;
    send_byte(w[15:8], thr);
    send_byte(w[7:0], thr);
    if (over) begin
      repeat (3) @(negedge Clk);
      chk("err_flag", error, 1);
      chk("err_hold", cpu_hold, 1);
      chk("err_ready", in_ready, 0);
      chk("err_done", done, 0);
      chk("err_writes", we_count - we0, 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], thr);
      end
      chk("done_flag", done, 1);
      chk("final_we", imem_we, (n > 0) ? 1 : 0);
      chk("hold_at_done", cpu_hold, 1);
      chk("words_loaded", words_loaded, n);
      chk("no_error", error, 0);
      @(negedge Clk);
      chk("hold_released", cpu_hold, 0);
      chk("ready_low_done", in_ready, 0);
      chk("write_count", we_count - we0, n);
      chk("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_addr_data_wl", {imem_addr, imem_wdata, words_loaded}, 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Two-word load, back-to-back then throttled.
    img = '{32'h20080005, 32'h01095020};
    run_load(2, 1'b0);
    run_load(2, 1'b1);

    // Zero length.
    img.delete();
    run_load(0, 1'b0);

    // Over capacity, then retry with a valid image.
    run_load(257, 1'b0);
    img = '{32'hDEADBEEF, 32'h00000001, 32'h80000000};
    run_load(3, 1'b1);
    chk("error_cleared", error, 0);

    // Full capacity, word value = address.
    img.delete();
    for (int i = 0; i < (1 << AW); i++) img.push_back(i);
    run_load(1 << AW, 1'b0);

    // Random images.
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 6);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      run_load(n, k[0]);
    end

    // Reset mid-load: after word 0 and three bytes of word 1.
    img = '{32'h11223344, 32'h55667788};
    exp_q.push_back({8'd0, img[0]});
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(img[0][31-8*b -: 8], 1'b0);
    for (int b = 0; b < 3; b++) send_byte(img[1][31-8*b -: 8], 1'b0);
    chk("midload_hold", cpu_hold, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_rst_flags", {in_ready, imem_we, cpu_hold, done, error}, 0);
    chk("async_rst_addr_data_wl", {imem_addr, imem_wdata, words_loaded}, 0);
    chk("midload_queue", exp_q.size(), 0);
    exp_q.delete();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    img = '{32'hCAFEF00D};
    run_load(1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the pipelined CPU. It accepts a byte stream carrying a length header and instruction words, and packs the bytes big-endian into 32-bit words. It writes the words sequentially into instruction memory from word address 0, keeping the CPU frozen with `cpu_hold` until the image is complete. It writes the same memory that the IF stage reads through `PCtoInsMem`/`IFinstructions`.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity is 2**ADDR_W words.
- `Clk`  in  1  — single clock; all state on rising edge.
- `Reset`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — one-cycle pulse; begins a load when the block is in IDLE, DONE or ERR.
- `in_valid`  in  1  — source has a byte on `in_data`.
- `in_data`  in  8  — stream byte.
- `in_ready`  out  1  — loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `imem_we`  out  1  — one-cycle write strobe to instruction memory.
- `imem_addr`  out  ADDR_W  — word address for the write.
- `imem_wdata`  out  32  — instruction word.
- `cpu_hold`  out  1  — high while a load is in progress; the CPU uses it to gate PC write.
- `done`  out  1  — level; the last load completed successfully.
- `error`  out  1  — level; the last load was rejected because the header exceeded capacity.
- `words_loaded`  out  ADDR_W+1  — count of words written in the current or last load.

## Operation
- The loader is a state machine with states IDLE, HDR, DATA, DONE and ERR.
- **Reset values:** state=IDLE; `in_ready`, `imem_we`, `cpu_hold`, `done` and `error` are 0; `imem_addr`, `imem_wdata` and `words_loaded` are 0. Instruction-memory contents are not touched by reset.
- **Start.** `start` in IDLE, DONE or ERR moves to HDR at the next edge.
  - At that edge: `cpu_hold`=1, `done`=0, `error`=0, `words_loaded`=0, byte counter=0.
  - `start` in HDR or DATA is ignored.
- **HDR** (`in_ready`=1): collects 2 bytes, high byte first, into a 16-bit count N.
  - If N=0, go to DONE.
  - If N>2**ADDR_W, go to ERR.
  - Otherwise go to DATA.
- **DATA** (`in_ready`=1): accepted bytes fill the word big-endian. Byte 0 goes to bits 31:24 and byte 3 to bits 7:0.
  - On the edge that accepts byte 3: `imem_wdata`=assembled word, `imem_addr`=`words_loaded`[ADDR_W-1:0], `imem_we`=1 for exactly the next cycle, and `words_loaded` increments.
  - If that word was word N-1, the state goes to DONE on the same edge.
- **Streaming.** Bytes may arrive back-to-back with no bubbles. Gaps in `in_valid` merely stall; the byte counter holds.
- **DONE:** `in_ready`=0 and `done`=1. `cpu_hold` clears one edge after entry, so it is never low while the final `imem_we` is high.
- **ERR:** `in_ready`=0, `error`=1, `cpu_hold` stays 1, and no writes have occurred. A new `start` retries.
- **Invariant:** `imem_we` is never high in IDLE, HDR or ERR except for the trailing final-word pulse.

## Timing
- Latency from accepting the 4th byte of a word to `imem_we` is 1 cycle.
- Minimum load time is 1 (start) + 2 + 4N byte cycles.
- `done` rises at the same edge as the final `imem_we`.
- `cpu_hold` falls at the following edge.
- For N=0, `done`=1 and `cpu_hold`=0 take effect at successive edges after the second header byte.
- Asynchronous `Reset` low at any point, including mid-word or mid-header, forces all outputs to their reset values immediately. A partially written image remains in memory and `done` stays 0.
- In IDLE, DONE and ERR, `in_ready`=0. A byte presented in the same cycle as `start` is not consumed.
- With N=2**ADDR_W, the final write goes to address 2**ADDR_W-1 and `words_loaded`=2**ADDR_W. This uses the full-width counter and there is no wrap.

## Test plan
- **Two-word load:** reset, then `start`, then bytes 00 02 20 08 00 05 01 09 50 20 back-to-back. Required:
  - writes mem[0]=0x20080005 and mem[1]=0x01095020;
  - `done`=1 with `words_loaded`=2;
  - `cpu_hold` high from the edge after `start` until one edge after the second write.
- **Throttled source:** same image with `in_valid` low on random cycles. Required: the writes are identical, and `imem_we` pulses exactly twice, each 1 cycle wide.
- **Zero length:** header 00 00. Required: no `imem_we`, `done`=1, `words_loaded`=0, and `cpu_hold` returns to 0.
- **Over capacity:** `ADDR_W`=8 with header 01 01 (N=257). Required: `error`=1, `cpu_hold`=1, no writes, `in_ready`=0. A following `start` with a valid image then succeeds and `error` clears.
- **Full capacity:** header 01 00 with 256 words of value = address. Required: the last write is addr 0xFF with data 0x000000FF, and `words_loaded`=256.
- **Reset mid-load:** drop `Reset` after byte 2 of word 1. Required: all outputs are 0 immediately. After release, a new load rewrites from address 0.
